// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - minimal derived core configuration used by the TID allocator
package config_pkg;

  typedef struct packed {
    int unsigned MEM_TID_WIDTH;
    int unsigned DCACHE_MAX_TX;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{MEM_TID_WIDTH: 32'd2, DCACHE_MAX_TX: 32'd4};

endpackage

// File: rtl/mem_tid_allocator.sv
// rtl/mem_tid_allocator.sv - memory transaction ID allocator with release checking and timeouts
module mem_tid_allocator #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg       = config_pkg::cva6_cfg_empty,
  parameter int unsigned           TimeoutCycles = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              alloc_req_i,
  output logic                              alloc_gnt_o,
  output logic [CVA6Cfg.MEM_TID_WIDTH-1:0]  alloc_tid_o,
  input  logic                              rel_valid_i,
  input  logic [CVA6Cfg.MEM_TID_WIDTH-1:0]  rel_tid_i,
  output logic [CVA6Cfg.MEM_TID_WIDTH:0]    outstanding_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              err_rel_o,
  output logic                              timeout_valid_o,
  output logic [CVA6Cfg.MEM_TID_WIDTH-1:0]  timeout_tid_o
);

  localparam int TW = CVA6Cfg.MEM_TID_WIDTH;
  localparam int N  = 1 << TW;

  logic [N-1:0]  busy_q, busy_d;
  logic [TW:0]   count_q;
  logic          err_rel_q;
  logic          gnt;
  logic [TW-1:0] free_tid;
  logic          rel_ok, rel_bad;
  logic          full;

  assign full = (count_q == (TW+1)'(N));

  // Priority search over the registered busy vector only, so a same-cycle release is never re-granted.
  always_comb begin
    free_tid = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_tid = TW'(i);
    end
  end

  assign gnt     = alloc_req_i & ~full & ~flush_i;
  assign rel_ok  = rel_valid_i & ~flush_i & busy_q[rel_tid_i];
  assign rel_bad = rel_valid_i & ~flush_i & ~busy_q[rel_tid_i];

  always_comb begin
    busy_d = busy_q;
    if (rel_ok) busy_d[rel_tid_i] = 1'b0;
    if (gnt) busy_d[free_tid] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= '0;
      count_q   <= '0;
      err_rel_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      err_rel_q <= rel_bad;
      if (flush_i) count_q <= '0;
      else count_q <= count_q + {{TW{1'b0}}, gnt} - {{TW{1'b0}}, rel_ok};
    end
  end

  assign alloc_gnt_o   = gnt;
  assign alloc_tid_o   = free_tid;
  assign outstanding_o = count_q;
  assign full_o        = full;
  assign empty_o       = (count_q == '0);
  assign err_rel_o     = err_rel_q;

  if (TimeoutCycles > 0) begin : g_timeout
    localparam int AW = $clog2(TimeoutCycles + 1);
    localparam logic [AW-1:0] Limit = AW'(TimeoutCycles);

    logic [AW-1:0] age_q [N];
    logic [N-1:0]  timed_out_q, pend_q, pend_d, hit, cand;
    logic          found;
    logic [TW-1:0] first;
    logic          tv_q;
    logic [TW-1:0] tt_q;

    // IDs hitting the limit together queue up in pend_q and are reported one per cycle, lowest first.
    always_comb begin
      hit = '0;
      for (int i = 0; i < N; i++) begin
        hit[i] = busy_q[i] & (age_q[i] == Limit) & ~timed_out_q[i];
      end
      cand  = pend_q | hit;
      found = |cand;
      first = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (cand[i]) first = TW'(i);
      end
      pend_d = cand;
      if (found) pend_d[first] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < N; i++) age_q[i] <= '0;
        timed_out_q <= '0;
        pend_q      <= '0;
        tv_q        <= 1'b0;
        tt_q        <= '0;
      end else if (flush_i) begin
        for (int i = 0; i < N; i++) age_q[i] <= '0;
        timed_out_q <= '0;
        pend_q      <= '0;
        tv_q        <= 1'b0;
        tt_q        <= '0;
      end else begin
        pend_q <= pend_d;
        tv_q   <= found;
        tt_q   <= first;
        for (int i = 0; i < N; i++) begin
          if (gnt && (free_tid == TW'(i))) begin
            age_q[i]       <= '0;
            timed_out_q[i] <= 1'b0;
          end else begin
            if (busy_q[i] && (age_q[i] != Limit)) age_q[i] <= age_q[i] + 1'b1;
            if (rel_ok && (rel_tid_i == TW'(i))) timed_out_q[i] <= 1'b0;
            else if (hit[i]) timed_out_q[i] <= 1'b1;
          end
        end
      end
    end

    assign timeout_valid_o = tv_q;
    assign timeout_tid_o   = tt_q;
  end else begin : g_no_timeout
    assign timeout_valid_o = 1'b0;
    assign timeout_tid_o   = '0;
  end

endmodule

// File: tb/tb_mem_tid_allocator.sv
// tb/tb_mem_tid_allocator.sv - self-checking bench for mem_tid_allocator
module tb_mem_tid_allocator;

  localparam config_pkg::cva6_cfg_t Cfg = '{MEM_TID_WIDTH: 32'd2, DCACHE_MAX_TX: 32'd4};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       req = 1'b0;
  logic       gnt;
  logic [1:0] tid;
  logic       rv = 1'b0;
  logic [1:0] rt = '0;
  logic [2:0] outs;
  logic       full, empty, err, tv;
  logic [1:0] tt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_tid_allocator #(.CVA6Cfg(Cfg), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alloc_req_i(req), .alloc_gnt_o(gnt), .alloc_tid_o(tid),
    .rel_valid_i(rv), .rel_tid_i(rt),
    .outstanding_o(outs), .full_o(full), .empty_o(empty),
    .err_rel_o(err), .timeout_valid_o(tv), .timeout_tid_o(tt)
  );

  typedef struct {
    logic       flush, req, rv;
    logic [1:0] rt;
    logic       gnt;
    logic [1:0] tid;
    logic [2:0] outs;
    logic       full, empty, err;
  } vec_t;

  typedef struct {
    int         idx;
    logic [2:0] outs;
    logic       full, empty, err;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, want);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    flush = v.flush; req = v.req; rv = v.rv; rt = v.rt;
    #1;
    chk("gnt", idx, gnt, v.gnt);
    chk("tid", idx, tid, v.tid);
    e = '{idx: idx, outs: v.outs, full: v.full, empty: v.empty, err: v.err};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("outstanding", e.idx, outs, e.outs);
    chk("full", e.idx, full, e.full);
    chk("empty", e.idx, empty, e.empty);
    chk("err_rel", e.idx, err, e.err);
  endtask

  initial begin
    // flush req rv rt | gnt tid outs full empty err
    vecs.push_back('{0, 1, 0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 1, 2, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 2, 3, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 3, 4, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 4, 1, 0, 0});
    vecs.push_back('{0, 1, 1, 2, 0, 0, 3, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 2, 4, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 1, 2, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 1, 2, 2, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 0, 3, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 1, 0, 3, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 1, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 3, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0});

    // reset values
    #12;
    chk("rst_outstanding", 0, outs, 0);
    chk("rst_full", 0, full, 0);
    chk("rst_empty", 0, empty, 1);
    chk("rst_err", 0, err, 0);
    chk("rst_tv", 0, tv, 0);
    chk("rst_tt", 0, tt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step(i, vecs[i]);
    @(negedge clk);
    flush = 0; req = 0; rv = 0; rt = 0;

    // asynchronous reset mid-operation, with an error pulse in flight
    @(negedge clk); req = 1;
    @(posedge clk); #1;
    @(negedge clk); req = 1;
    @(posedge clk); #1;
    chk("mid_outstanding", 0, outs, 2);
    @(negedge clk); req = 0; rv = 1; rt = 3;
    @(posedge clk); #1;
    chk("mid_err", 0, err, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outstanding", 0, outs, 0);
    chk("mid_rst_empty", 0, empty, 1);
    chk("mid_rst_err", 0, err, 0);
    @(negedge clk); rv = 0; rt = 0; rst_n = 1'b1;

    // timeouts for two back-to-back grants, then a re-grant of tid 0
    @(negedge clk); req = 1;
    @(posedge clk); #1;
    @(negedge clk); req = 1;
    @(posedge clk); #1;
    @(negedge clk); req = 0;
    for (int j = 2; j <= 24; j++) begin
      @(posedge clk); #1;
      chk("to_valid", j, tv, (j == 9 || j == 10) ? 1 : 0);
      if (j == 9 || j == 10) chk("to_tid", j, tt, (j == 10) ? 1 : 0);
    end
    @(negedge clk); rv = 1; rt = 0;
    @(posedge clk); #1;
    @(negedge clk); rv = 0; req = 1;
    #1;
    chk("regrant_tid", 0, tid, 0);
    chk("regrant_gnt", 0, gnt, 1);
    @(posedge clk); #1;
    @(negedge clk); req = 0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      chk("to2_valid", j, tv, (j == 9) ? 1 : 0);
      if (j == 9) chk("to2_tid", j, tt, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
